// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_REQ,
    ST_HOLD,
    ST_DRAIN
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES          = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry output/skid register between instruction memory and decode.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  input  logic        consume,
  input  logic        clear,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (clear) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (consume) begin
      // Skid always drains ahead of a fresh load to keep program order.
      if (skid_valid) begin
        out_instr  <= skid_instr;
        out_pc     <= skid_pc;
        skid_valid <= load;
        if (load) begin
          skid_instr <= load_instr;
          skid_pc    <= load_pc;
        end
      end else if (load) begin
        out_instr <= load_instr;
        out_pc    <= load_pc;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (load) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_instr <= load_instr;
        out_pc    <= load_pc;
      end else begin
        skid_valid <= 1'b1;
        skid_instr <= load_instr;
        skid_pc    <= load_pc;
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: next-PC selection, imem req/ack handshake,
// redirect/trap handling and buffered delivery toward decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_valid,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush,
  output logic        misalign_err
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pending;
  logic         pend_load;
  logic         buf_load;
  logic         buf_clear;
  logic         consume;
  logic         ev_any;
  logic         ev_misalign;
  logic [31:0]  ev_target;
  logic [31:0]  pc_seq;

  assign consume     = if_valid & ~stall_in;
  assign ev_any      = trap_valid | redirect_valid;
  assign ev_misalign = redirect_valid & ~trap_valid & is_misaligned(redirect_target);
  assign ev_target   = (trap_valid || ev_misalign) ? TRAP_VECTOR : redirect_target;
  assign pc_seq      = pc_in + 32'(INSTR_BYTES);
  assign imem_addr   = pc_in;

  always_comb begin
    state_nxt = state;
    pc_next   = pc_in;
    imem_req  = 1'b0;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    pend_load = 1'b0;
    if (!rst_in) begin
      state_nxt = ST_BOOT;
      pc_next   = RESET_VECTOR;
    end else begin
      case (state)
        ST_BOOT: begin
          state_nxt = ST_REQ;
          pc_next   = RESET_VECTOR;
          if (ev_any) begin
            buf_clear = 1'b1;
            pc_next   = ev_target;
          end
        end
        ST_REQ: begin
          imem_req = 1'b1;
          if (ev_any) begin
            buf_clear = 1'b1;
            if (imem_ack) begin
              pc_next = ev_target;
            end else begin
              pend_load = 1'b1;
              state_nxt = ST_DRAIN;
            end
          end else if (imem_ack) begin
            buf_load = 1'b1;
            pc_next  = pc_seq;
            if (if_valid && !consume) state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ev_any) begin
            buf_clear = 1'b1;
            pc_next   = ev_target;
            state_nxt = ST_REQ;
          end else if (consume) begin
            state_nxt = ST_REQ;
          end
        end
        ST_DRAIN: begin
          // Outstanding request must complete before the new target is issued.
          imem_req = 1'b1;
          if (ev_any) begin
            buf_clear = 1'b1;
            if (imem_ack) begin
              pc_next   = ev_target;
              state_nxt = ST_REQ;
            end else begin
              pend_load = 1'b1;
            end
          end else if (imem_ack) begin
            pc_next   = pending;
            state_nxt = ST_REQ;
          end
        end
        default: state_nxt = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state        <= ST_BOOT;
      pending      <= '0;
      flush        <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      flush        <= ev_any;
      misalign_err <= ev_misalign;
      if (pend_load) pending <= ev_target;
    end
  end

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst_in     (rst_in),
    .load       (buf_load),
    .load_instr (imem_rdata),
    .load_pc    (pc_in),
    .consume    (consume),
    .clear      (buf_clear),
    .out_valid  (if_valid),
    .out_instr  (if_instr),
    .out_pc     (if_pc)
  );

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the `PC_Next` input of the program-counter register and sequences instruction-memory reads. It chooses the next PC from reset vector, trap vector, branch/jump redirect or sequential `+4`. It runs a req/ack handshake to instruction memory and buffers fetched instructions toward decode through a two-entry output/skid path with `valid`/`~stall` flow control. It sits between the PC register, instruction memory and the IF/ID boundary.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- TRAP_VECTOR, 32'h0000_0100, target on `trap_valid` or misaligned redirect

Ports:
- clk  in  1  clock, all state on rising edge
- rst_in  in  1  reset, synchronous, active-low
- pc_in  in  32  current PC register value
- pc_next  out  32  next value for PC register, combinational
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, equals `pc_in`
- imem_ack  in  1  memory completion; `imem_rdata` valid this cycle
- imem_rdata  in  32  fetched instruction
- stall_in  in  1  decode cannot accept this cycle
- redirect_valid  in  1  branch/jump taken
- redirect_target  in  32  redirect address
- trap_valid  in  1  exception/interrupt entry
- if_valid  out  1  `if_instr`/`if_pc` hold a valid instruction
- if_instr  out  32  instruction to decode
- if_pc  out  32  address of `if_instr`
- flush  out  1  one-cycle pulse, pipeline kill after redirect/trap
- misalign_err  out  1  one-cycle pulse, redirect target with `[1:0]≠0`

## Operation
- FSM states: BOOT, REQ, HOLD, DRAIN.
- Reset (`rst_in`=0 at edge): state←BOOT, `if_valid`←0, skid empty, `flush`←0, `misalign_err`←0, `if_instr`/`if_pc`←0. While `rst_in`=0, `pc_next`=RESET_VECTOR and `imem_req`=0.
- BOOT: `imem_req`=0, `pc_next`=RESET_VECTOR. Next state REQ.
- REQ: `imem_req`=1 and `imem_addr`=`pc_in`. Address stays stable until ack.
  - On ack with no control event:
    - If the output register is empty or being consumed (`if_valid & ~stall_in`): load output with {rdata, pc_in} and set `pc_next`=`pc_in`+4.
    - Otherwise: load skid, set `pc_next`=`pc_in`+4, go to HOLD.
  - With no ack, `pc_next`=`pc_in`.
- HOLD: `imem_req`=0. When output is consumed, skid moves to output and the state returns to REQ.
- Control events, priority trap > redirect:
  - Target is TRAP_VECTOR on trap. On redirect it is `redirect_target`, or TRAP_VECTOR if misaligned, with `misalign_err` pulsed.
  - Output register and skid are cleared. `flush` pulses next cycle.
  - In REQ without ack: latch target in pending register, go to DRAIN, keep req/addr until ack.
  - In BOOT/HOLD, or REQ with ack: `pc_next`=target, go to REQ; ack data is discarded.
- DRAIN: `imem_req`=1 with the old address. On ack, discard data, set `pc_next`=pending, go to REQ. A newer event in DRAIN overwrites pending (trap still wins).
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 → 0.

## Timing
- Zero-wait memory gives 1 instruction/cycle with no bubbles. Ack at edge N means `if_valid` is high after edge N.
- Redirect at edge N: PC = target after N. First target request is in cycle N+1 (REQ case) or after the drain ack. `flush` is high in cycle N+1 only.
- `if_valid` stays high with stable data while `stall_in`=1. Consumption is `if_valid & ~stall_in` at an edge.
- An event concurrent with consumption drops nothing already delivered; the consumed instruction counts as accepted.
- `pc_next` and `imem_*` are combinational from state and `pc_in`. All other outputs are registered.

## Structure
- `fetch_pkg`: state enum, INSTR_BYTES=4, default vectors.
- One sub-module, `fetch_skid_buf`: two-entry output/skid register with load, consume, and clear inputs.
- Top level holds the FSM, pending-target register, and next-PC mux.

## Test plan
- Reset release, RESET_VECTOR=0, zero-wait ack: `if_pc` = 0,4,8,12 on consecutive cycles; `imem_req`=0 in BOOT.
- Ack every cycle, `stall_in` high 3 cycles at pc 8: output holds pc 8, skid holds 12, `imem_req`=0. After release, delivers 8 then 12, then fetches 16.
- Redirect to 32'h200 while a 2-wait-state request is pending at 0x10: DRAIN, ack data discarded, next `imem_addr`=0x200, `flush` pulses once.
- Same cycle `trap_valid` and `redirect_valid`(0x300): PC = 0x100, `flush` pulses.
- Redirect to 0x202: `misalign_err` pulses, PC = 0x100.
- `rst_in` low mid-DRAIN: `if_valid`=0, state BOOT, `pc_next`=RESET_VECTOR. Also 0xFFFF_FFFC wraps to 0.
